// File: rtl/alu_mul_seq.sv
// Sequential shift-and-add multiplier that borrows the shared ALU for every add and shift.
// Produces the low WIDTH bits of mcand*mplier and stops as soon as the remaining multiplier is zero.
module alu_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] mcand,
  input  logic [WIDTH-1:0] mplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic             alu_own,
  output logic [WIDTH-1:0] alu_opA,
  output logic [WIDTH-1:0] alu_opB,
  output logic [3:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_res,
  input  logic             alu_zero
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADD,
    S_SHL,
    S_SHR,
    S_DONE
  } state_e;

  localparam logic [3:0] SEL_DEF = 4'b0000;
  localparam logic [3:0] SEL_ADD = 4'b0001;
  localparam logic [3:0] SEL_SLL = 4'b1100;
  localparam logic [3:0] SEL_SRL = 4'b1000;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mc_q, mc_d;
  logic [WIDTH-1:0] mp_q, mp_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] product_q, product_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             own_q, own_d;

  // ALU drive is decoded straight from the current state so the result returns in the same cycle.
  always_comb begin
    alu_opA = '0;
    alu_opB = '0;
    alu_sel = SEL_DEF;
    case (state_q)
      S_ADD: begin
        alu_sel = SEL_ADD;
        alu_opA = acc_q;
        alu_opB = mc_q;
      end
      S_SHL: begin
        alu_sel = SEL_SLL;
        alu_opA = WIDTH'(1);
        alu_opB = mc_q;
      end
      S_SHR: begin
        alu_sel = SEL_SRL;
        alu_opA = WIDTH'(1);
        alu_opB = mp_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    mc_d      = mc_q;
    mp_d      = mp_q;
    acc_d     = acc_q;
    product_d = product_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mc_d    = mcand;
          mp_d    = mplier;
          acc_d   = '0;
          state_d = (mplier == '0) ? S_DONE : S_ADD;
        end
      end
      S_ADD: begin
        if (mp_q[0]) acc_d = alu_res;
        state_d = S_SHL;
      end
      S_SHL: begin
        mc_d    = alu_res;
        state_d = S_SHR;
      end
      S_SHR: begin
        mp_d    = alu_res;
        state_d = alu_zero ? S_DONE : S_ADD;
      end
      S_DONE: begin
        product_d = acc_q;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Status flags are registered from the next state so they line up exactly with state_q.
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
    own_d  = (state_d == S_ADD) || (state_d == S_SHL) || (state_d == S_SHR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      mc_q      <= '0;
      mp_q      <= '0;
      acc_q     <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      own_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mc_q      <= mc_d;
      mp_q      <= mp_d;
      acc_q     <= acc_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      own_q     <= own_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign alu_own = own_q;
  assign product = product_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Bench for alu_mul_seq: a simple ALU model, an arithmetic reference of the whole multiply
// timeline, directed scenarios with literal expectations and a randomized start/reset phase.
module tb_alu_mul_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] mcand = '0;
  logic [31:0] mplier = '0;
  logic        busy, done, alu_own, alu_zero;
  logic [31:0] product, alu_opA, alu_opB, alu_res;
  logic [3:0]  alu_sel;

  int pass_cnt = 0;
  int total_cnt = 0;
  bit chk_en = 1'b0;

  alu_mul_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .mcand(mcand), .mplier(mplier),
    .busy(busy), .done(done), .product(product), .alu_own(alu_own),
    .alu_opA(alu_opA), .alu_opB(alu_opB), .alu_sel(alu_sel),
    .alu_res(alu_res), .alu_zero(alu_zero)
  );

  always #5 clk = ~clk;

  // Shared ALU: shifts move opB by opA.
  always_comb begin
    alu_res = '0;
    case (alu_sel)
      4'b0001: alu_res = alu_opA + alu_opB;
      4'b1100: alu_res = alu_opB << alu_opA[4:0];
      4'b1000: alu_res = alu_opB >> alu_opA[4:0];
      default: alu_res = '0;
    endcase
    alu_zero = (alu_res == '0);
  end

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endfunction

  function automatic int iters(input logic [31:0] b);
    int n = 0;
    for (int i = 0; i < 32; i++) if (b[i]) n = i + 1;
    return n;
  endfunction

  // Reference timeline: cyc counts cycles since the accepting edge; done lands in cycle 3N+1.
  bit          m_active = 1'b0;
  int          m_cyc = 0;
  int          m_n = 0;
  logic [31:0] m_a = '0, m_b = '0, m_prod = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_active = 1'b0;
      m_cyc    = 0;
      m_prod   = '0;
    end else if (!m_active) begin
      if (start) begin
        m_active = 1'b1;
        m_cyc    = 1;
        m_a      = mcand;
        m_b      = mplier;
        m_n      = iters(mplier);
      end
    end else if (m_cyc == 3 * m_n + 1) begin
      m_prod   = m_a * m_b;
      m_active = 1'b0;
      m_cyc    = 0;
    end else begin
      m_cyc++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic        e_own, e_done;
      logic [31:0] e_opa, e_opb, e_mask;
      logic [3:0]  e_sel;
      int          k, ph;
      e_own  = m_active && (m_cyc <= 3 * m_n);
      e_done = m_active && (m_cyc == 3 * m_n + 1);
      e_opa  = '0;
      e_opb  = '0;
      e_sel  = 4'b0000;
      if (e_own) begin
        k  = (m_cyc - 1) / 3 + 1;
        ph = (m_cyc - 1) % 3;
        e_mask = 32'((64'd1 << (k - 1)) - 64'd1);
        case (ph)
          0: begin e_sel = 4'b0001; e_opa = m_a * (m_b & e_mask); e_opb = m_a << (k - 1); end
          1: begin e_sel = 4'b1100; e_opa = 32'd1; e_opb = m_a << (k - 1); end
          default: begin e_sel = 4'b1000; e_opa = 32'd1; e_opb = m_b >> (k - 1); end
        endcase
      end
      chk("busy", {31'd0, busy}, {31'd0, m_active});
      chk("done", {31'd0, done}, {31'd0, e_done});
      chk("alu_own", {31'd0, alu_own}, {31'd0, e_own});
      chk("alu_sel", {28'd0, alu_sel}, {28'd0, e_sel});
      chk("alu_opA", alu_opA, e_opa);
      chk("alu_opB", alu_opB, e_opb);
      chk("product", product, m_prod);
    end
  end

  // Starts one multiply from IDLE; returns the cycle done was seen and whether alu_own ever rose.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit glitch,
                        output int dcyc, output bit own_seen);
    mcand = a;
    mplier = b;
    start = 1'b1;
    dcyc = -1;
    own_seen = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      start = glitch && (c == 2);
      if (glitch && c == 2) begin
        mcand = 32'h0000_1234;
        mplier = 32'h0000_0055;
      end
      if (alu_own) own_seen = 1'b1;
      if (done) begin
        dcyc = c;
        break;
      end
    end
    start = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int  dc;
    bit  own;
    bit  done_seen;
    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_own", {31'd0, alu_own}, 32'd0);
    chk("rst_sel", {28'd0, alu_sel}, 32'd0);
    chk("rst_product", product, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_opA", alu_opA, 32'd0);
    chk("idle_opB", alu_opB, 32'd0);

    run_op(32'd7, 32'd6, 1'b0, dc, own);
    chk("7x6_done_cyc", dc, 32'd10);
    chk("7x6_product", product, 32'd42);

    run_op(32'd5, 32'd0, 1'b0, dc, own);
    chk("5x0_done_cyc", dc, 32'd1);
    chk("5x0_product", product, 32'd0);
    chk("5x0_own", {31'd0, own}, 32'd0);

    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, dc, own);
    chk("ffxff_done_cyc", dc, 32'd97);
    chk("ffxff_product", product, 32'h0000_0001);

    run_op(32'h8000_0000, 32'd3, 1'b1, dc, own);
    chk("msb_x3_done_cyc", dc, 32'd7);
    chk("msb_x3_product", product, 32'h8000_0000);

    // Abort 9 x 0xF0 with a reset in cycle 5.
    mcand = 32'd9;
    mplier = 32'h0000_00F0;
    start = 1'b1;
    done_seen = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) done_seen = 1'b1;
      rst = (c == 5);
    end
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_product", product, 32'd0);
    chk("abort_no_done", {31'd0, done_seen}, 32'd0);

    run_op(32'd3, 32'd4, 1'b0, dc, own);
    chk("3x4_done_cyc", dc, 32'd10);
    chk("3x4_product", product, 32'd12);

    for (int i = 0; i < 12; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      run_op(a, b, 1'b0, dc, own);
      chk("rand_done_cyc", dc, 3 * iters(b) + 1);
      chk("rand_product", product, a * b);
    end

    // Free-running starts (often held high), operand churn and occasional resets.
    for (int i = 0; i < 1500; i++) begin
      start = ($urandom_range(0, 2) != 0);
      mcand = $urandom;
      mplier = $urandom >> $urandom_range(0, 31);
      rst = ($urandom_range(0, 199) == 0);
      @(negedge clk);
    end
    start = 1'b0;
    rst = 1'b0;
    repeat (110) @(negedge clk);
    chk("drain_idle", {31'd0, busy}, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
